// File: rtl/minisys_pkg.sv
// Shared definitions for the data-memory arbiter slice: FSM states,
// port indices and the default starvation limit.
package minisys_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int unsigned PORT0 = 0;
  localparam int unsigned PORT1 = 1;

  localparam int unsigned STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive port-0 grants while port 1 waits; flags
// when port 1 must take priority at the next arbitration.
module arb_starve_cnt
  import minisys_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
  input  logic p0_grant,
  input  logic p1_req,
  output logic p1_priority
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any arbitration that is not a port-0 win over a waiting port 1 clears.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_en) begin
      if (p0_grant && p1_req) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign p1_priority = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous data memory:
// port 0 (CPU) has priority, bounded by a starvation limit for port 1.
module dmem_arbiter
  import minisys_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);

  arb_state_e    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          rd_q, rd_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          arb_en, grant0, grant1, p1_priority;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clock       (clock),
    .reset       (reset),
    .arb_en      (arb_en),
    .p0_grant    (grant0),
    .p1_req      (p1_req),
    .p1_priority (p1_priority)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rd_d       = rd_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    arb_en     = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;

    unique case (state_q)
      ST_ACCESS: begin
        if (owner_q[PORT1]) begin
          mem_addr  = p1_addr;
          mem_wdata = p1_wdata;
          mem_we    = p1_we;
          rd_d      = ~p1_we;
        end else begin
          mem_addr  = p0_addr;
          mem_wdata = p0_wdata;
          mem_we    = p0_we;
          rd_d      = ~p0_we;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        p0_ack = owner_q[PORT0];
        p1_ack = owner_q[PORT1];
        if (rd_q && owner_q[PORT0]) p0_rdata_d = mem_rdata;
        if (rd_q && owner_q[PORT1]) p1_rdata_d = mem_rdata;
      end
      default: ;
    endcase

    // IDLE and RESP both arbitrate; an unreachable encoding also falls in here.
    if (state_q != ST_ACCESS) begin
      arb_en  = 1'b1;
      grant1  = p1_req && (p1_priority || !p0_req);
      grant0  = p0_req && !grant1;
      owner_d = {grant1, grant0};
      state_d = (grant0 || grant1) ? ST_ACCESS : ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rd_q       <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // Read data is forwarded in the ack cycle and held by the register after it.
  assign p0_rdata = p0_rdata_d;
  assign p1_rdata = p1_rdata_d;
  assign owner    = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed sequences, a grant-order vector table and
// randomized traffic against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int unsigned SMAX = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p1_ack, mem_we;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  owner;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.STARVE_MAX(SMAX), .DW(32), .AW(32)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clock = ~clock;

  // Synchronous memory: write and registered read on the same edge.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  function automatic logic [31:0] init_pat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_owner"}, owner, 0);
    chk({p, "_ack0"}, p0_ack, 0);
    chk({p, "_ack1"}, p1_ack, 0);
    chk({p, "_we"}, mem_we, 0);
    chk({p, "_addr"}, mem_addr, 0);
    chk({p, "_wdata"}, mem_wdata, 0);
    chk({p, "_rdata0"}, p0_rdata, 0);
    chk({p, "_rdata1"}, p1_rdata, 0);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] m_held [2];
  bit          m_act;
  int          m_age, m_port, m_sc;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
  endfunction

  task automatic model_step();
    bit w1;
    if (m_act && m_age == 1) begin
      m_age = 2;
    end else begin
      if (m_act) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_held[m_port] = ref_rd(m_addr);
        m_act = 0;
      end
      if (p0_req || p1_req) begin
        w1 = p1_req && (!p0_req || m_sc >= int'(SMAX));
        if (!w1 && p1_req) m_sc = (m_sc < int'(SMAX)) ? m_sc + 1 : int'(SMAX);
        else               m_sc = 0;
        m_act   = 1;
        m_age   = 1;
        m_port  = w1 ? 1 : 0;
        m_we    = w1 ? p1_we : p0_we;
        m_addr  = w1 ? p1_addr : p0_addr;
        m_wdata = w1 ? p1_wdata : p0_wdata;
      end else begin
        m_sc = 0;
      end
    end
  endtask

  task automatic model_check();
    bit a0, a1, acc;
    acc = m_act && m_age == 1;
    a0  = m_act && m_age == 2 && m_port == 0;
    a1  = m_act && m_age == 2 && m_port == 1;
    chk("rnd_owner", owner, !m_act ? 2'b00 : (m_port == 1 ? 2'b10 : 2'b01));
    chk("rnd_ack0", p0_ack, a0);
    chk("rnd_ack1", p1_ack, a1);
    chk("rnd_we", mem_we, acc && m_we);
    chk("rnd_addr", mem_addr, acc ? m_addr : 32'h0);
    chk("rnd_wdata", mem_wdata, acc ? m_wdata : 32'h0);
    chk("rnd_rdata0", p0_rdata, (a0 && !m_we) ? ref_rd(m_addr) : m_held[0]);
    chk("rnd_rdata1", p1_rdata, (a1 && !m_we) ? ref_rd(m_addr) : m_held[1]);
  endtask

  // ---------------- random requesters ----------------
  int          ps [2];   // 0 idle, 1 requesting, 2 dropped and awaiting ack
  logic        rq [2], rwe [2];
  logic [31:0] radr [2], rwd [2];

  task automatic gen_stim();
    bit ackn, accn;
    for (int p = 0; p < 2; p++) begin
      ackn = m_act && m_age == 2 && m_port == p;
      accn = m_act && m_age == 1 && m_port == p;
      if (ps[p] != 0 && ackn) ps[p] = 0;
      if (ps[p] == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          ps[p]   = 1;
          rq[p]   = 1'b1;
          rwe[p]  = 1'($urandom_range(0, 1));
          radr[p] = 32'h100 + (32'($urandom_range(0, 191)) << 2);
          rwd[p]  = $urandom;
        end else begin
          rq[p] = 1'b0;
        end
      end else if (ps[p] == 1 && accn && $urandom_range(0, 3) == 0) begin
        ps[p] = 2;
        rq[p] = 1'b0;
      end
    end
    p0_req = rq[0]; p0_we = rwe[0]; p0_addr = radr[0]; p0_wdata = rwd[0];
    p1_req = rq[1]; p1_we = rwe[1]; p1_addr = radr[1]; p1_wdata = rwd[1];
  endtask

  // ---------------- grant-order vector table ----------------
  typedef struct {
    logic       r0;
    logic       r1;
    logic [1:0] own;
    logic       ack0;
    logic       ack1;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{1, 1, 2'b01, 0, 0};
    tbl[1]  = '{1, 1, 2'b01, 1, 0};
    tbl[2]  = '{1, 1, 2'b01, 0, 0};
    tbl[3]  = '{1, 1, 2'b01, 1, 0};
    tbl[4]  = '{1, 1, 2'b01, 0, 0};
    tbl[5]  = '{1, 1, 2'b01, 1, 0};
    tbl[6]  = '{1, 1, 2'b10, 0, 0};
    tbl[7]  = '{1, 1, 2'b10, 0, 1};
    tbl[8]  = '{1, 1, 2'b01, 0, 0};
    tbl[9]  = '{1, 1, 2'b01, 1, 0};
    tbl[10] = '{1, 1, 2'b01, 0, 0};
    tbl[11] = '{1, 1, 2'b01, 1, 0};
    tbl[12] = '{1, 1, 2'b01, 0, 0};
    tbl[13] = '{1, 1, 2'b01, 1, 0};
    tbl[14] = '{1, 1, 2'b10, 0, 0};
    tbl[15] = '{1, 1, 2'b10, 0, 1};
    tbl[16] = '{0, 0, 2'b00, 0, 0};

    for (int i = 0; i < 256; i++) mem[i] = init_pat(32'(i * 4));
    mem[8] = 32'h12345678;

    #1 reset = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    // p0 write then read back
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    cyc();
    chk("wr_owner", owner, 2'b01);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_noack", p0_ack, 0);
    cyc();
    chk("wr_ack", p0_ack, 1);
    chk("wr_we_off", mem_we, 0);
    chk("wr_addr_off", mem_addr, 0);
    chk("wr_ack1", p1_ack, 0);
    p0_req = 0;
    cyc();
    chk("wr_idle", owner, 0);
    chk("wr_ack_once", p0_ack, 0);
    p0_we = 0; p0_wdata = 0; p0_req = 1;
    cyc();
    chk("rd_we", mem_we, 0);
    chk("rd_addr", mem_addr, 32'h10);
    cyc();
    chk("rd_ack", p0_ack, 1);
    chk("rd_data", p0_rdata, 32'hDEADBEEF);
    p0_req = 0;
    cyc();
    chk("rd_hold", p0_rdata, 32'hDEADBEEF);
    chk("rd_idle", owner, 0);

    // p1 alone reads 0x20
    p1_req = 1; p1_we = 0; p1_addr = 32'h20;
    cyc();
    chk("p1_owner", owner, 2'b10);
    chk("p1_addr", mem_addr, 32'h20);
    cyc();
    chk("p1_ack", p1_ack, 1);
    chk("p1_ack0", p0_ack, 0);
    chk("p1_rdata", p1_rdata, 32'h12345678);
    chk("p1_p0keep", p0_rdata, 32'hDEADBEEF);
    p1_req = 0;
    cyc();

    // p1 drops req one cycle after issue
    p1_req = 1; p1_addr = 32'h10;
    cyc();
    chk("drop_owner", owner, 2'b10);
    p1_req = 0;
    cyc();
    chk("drop_ack", p1_ack, 1);
    chk("drop_rdata", p1_rdata, 32'hDEADBEEF);
    cyc();
    chk("drop_idle", owner, 0);
    chk("drop_once", p1_ack, 0);

    // both held: starvation limit forces every fourth grant to port 1
    p0_addr = 32'h10; p1_addr = 32'h20;
    for (int i = 0; i < 17; i++) begin
      p0_req = tbl[i].r0; p1_req = tbl[i].r1;
      cyc();
      chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
      chk($sformatf("tbl%0d_ack0", i), p0_ack, tbl[i].ack0);
      chk($sformatf("tbl%0d_ack1", i), p1_ack, tbl[i].ack1);
    end

    // p0 back-to-back reads with req held
    p0_req = 1; p0_we = 0;
    for (int k = 0; k < 4; k++) begin
      p0_addr = 32'h100 + 32'(k * 4);
      cyc();
      chk($sformatf("b2b%0d_acc", k), {owner, p0_ack}, {2'b01, 1'b0});
      chk($sformatf("b2b%0d_addr", k), mem_addr, p0_addr);
      cyc();
      chk($sformatf("b2b%0d_ack", k), {owner, p0_ack}, {2'b01, 1'b1});
      chk($sformatf("b2b%0d_rdata", k), p0_rdata, init_pat(p0_addr));
    end
    p0_req = 0;
    cyc();
    chk("b2b_idle", owner, 0);

    // reset in the ACCESS cycle of a write
    p0_req = 1; p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'hCAFEF00D;
    cyc();
    chk("rstacc_we", mem_we, 1);
    #2 reset = 1'b0;
    #1 chk_zero("rstacc");
    p0_req = 0; p0_we = 0;
    repeat (2) @(posedge clock);
    #1 chk("rstacc_nowrite", mem[12], init_pat(32'h30));
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rstacc_noack", p0_ack, 0);
      chk("rstacc_idle", owner, 0);
    end

    // randomized traffic against the reference model
    m_act = 0; m_age = 0; m_port = 0; m_sc = 0;
    m_held[0] = 0; m_held[1] = 0;
    for (int p = 0; p < 2; p++) begin
      ps[p] = 0; rq[p] = 0; rwe[p] = 0; radr[p] = 0; rwd[p] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      cyc();
      model_step();
      model_check();
      gen_stim();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
